// File: rtl/accumulating_adder_tree_pkg.sv
// Shared sizing helpers for the accumulating adder tree: stage counts,
// per-stage word widths and pipeline register placement.
package accumulating_adder_tree_pkg;

    // Number of pairwise reduction levels needed to bring n lanes to one word.
    function automatic int tree_stages(input int n);
        return $clog2(n);
    endfunction

    // Words produced by reduction level s (ceil(n / 2^(s+1))).
    function automatic int stage_count(input int n, input int s);
        return (n + (1 << (s + 1)) - 1) >> (s + 1);
    endfunction

    // Word width produced by reduction level s: one growth bit per level.
    function automatic int stage_width(input int w, input int s);
        return w + s + 1;
    endfunction

    // Pipeline registers in the tree: one every r levels, last level always.
    function automatic int num_pipe_regs(input int n, input int r);
        return (tree_stages(n) + r - 1) / r;
    endfunction

    // Whether level s of an nstages-deep tree carries a register.
    function automatic bit stage_registered(input int s, input int nstages, input int r);
        return (((s + 1) % r) == 0) || (s == nstages - 1);
    endfunction

    // Flat bus width large enough to carry any level of the tree.
    function automatic int flat_width(input int n, input int w);
        return n * (w + tree_stages(n));
    endfunction

endpackage

// File: rtl/accumulating_adder_tree_stage.sv
// One reduction level: adds lane pairs with sign extension, passes an odd
// orphan through sign-extended, optionally registers the result.
module accumulating_adder_tree_stage
    import accumulating_adder_tree_pkg::*;
#(
    parameter int NUM_IN     = 2,
    parameter int IN_WIDTH   = 8,
    parameter bit REGISTERED = 1'b1,
    localparam int NUM_OUT   = stage_count(NUM_IN, 0),
    localparam int OUT_WIDTH = IN_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         en,
    input  logic [NUM_IN*IN_WIDTH-1:0]   operands,
    input  logic                         op_valid,
    input  logic                         op_last,
    output logic [NUM_OUT*OUT_WIDTH-1:0] sums,
    output logic                         sum_valid,
    output logic                         sum_last
);

    logic [NUM_OUT*OUT_WIDTH-1:0] sum_c;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_word
        logic signed [IN_WIDTH-1:0] lo;
        assign lo = operands[2*i*IN_WIDTH +: IN_WIDTH];
        if (2 * i + 1 < NUM_IN) begin : g_pair
            logic signed [IN_WIDTH-1:0] hi;
            assign hi = operands[(2*i+1)*IN_WIDTH +: IN_WIDTH];
            assign sum_c[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(lo) + OUT_WIDTH'(hi);
        end else begin : g_orphan
            assign sum_c[i*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(lo);
        end
    end

    if (REGISTERED) begin : g_reg
        logic [NUM_OUT*OUT_WIDTH-1:0] sums_p1;
        logic                         vld_p1;
        logic                         last_p1;

        // ---- stage register boundary ----
        // Control bits: cleared by reset, advance only when the datapath is enabled.
        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                vld_p1  <= 1'b0;
                last_p1 <= 1'b0;
            end else if (en) begin
                vld_p1  <= op_valid;
                last_p1 <= op_last;
            end
        end

        // Data words: no reset, qualified by vld_p1 downstream.
        always_ff @(posedge clk) begin
            if (en) begin
                sums_p1 <= sum_c;
            end
        end

        assign sums      = sums_p1;
        assign sum_valid = vld_p1;
        assign sum_last  = last_p1;
    end else begin : g_comb
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, arst_n, en};
        assign sums        = sum_c;
        assign sum_valid   = op_valid;
        assign sum_last    = op_last;
    end

endmodule

// File: rtl/accumulating_adder_tree.sv
// Pipelined signed adder tree that reduces NUM_INPUTS lanes per beat and
// accumulates the beats of a packet (closed by in_last) into one sum.
// A single enable derived from the output handshake freezes everything.
module accumulating_adder_tree
    import accumulating_adder_tree_pkg::*;
#(
    parameter int NUM_INPUTS  = 36,
    parameter int INPUT_WIDTH = 32,
    parameter int REG_EVERY   = 1,
    parameter int MAX_BEATS   = 16,
    localparam int OUT_WIDTH  = INPUT_WIDTH + $clog2(NUM_INPUTS) + $clog2(MAX_BEATS),
    localparam int BEATS_W    = $clog2(MAX_BEATS + 1)
) (
    input  logic                                clk,
    input  logic                                arst_n_in,
    input  logic [NUM_INPUTS*INPUT_WIDTH-1:0]   in,
    input  logic                                in_valid,
    input  logic                                in_last,
    output logic                                in_ready,
    output logic signed [OUT_WIDTH-1:0]         out,
    output logic [BEATS_W-1:0]                  out_beats,
    output logic                                out_overflow,
    output logic                                out_valid,
    input  logic                                out_ready
);

    localparam int S      = tree_stages(NUM_INPUTS);
    localparam int TREE_W = stage_width(INPUT_WIDTH, S - 1);
    localparam int FLAT_W = flat_width(NUM_INPUTS, INPUT_WIDTH);

    // Beat counter step that sticks at MAX_BEATS.
    function automatic logic [BEATS_W-1:0] sat_inc(input logic [BEATS_W-1:0] c);
        return (c == BEATS_W'(MAX_BEATS)) ? c : c + BEATS_W'(1);
    endfunction

    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // Level k of the tree lives in the low bits of tree_data[k].
    logic [S:0][FLAT_W-1:0] tree_data;
    logic [S:0]             tree_valid;
    logic [S:0]             tree_last;

    assign tree_data[0]  = FLAT_W'(in);
    assign tree_valid[0] = in_valid;
    assign tree_last[0]  = in_last;

    for (genvar s = 0; s < S; s++) begin : g_stage
        localparam int NI = (s == 0) ? NUM_INPUTS : stage_count(NUM_INPUTS, s - 1);
        localparam int IW = INPUT_WIDTH + s;
        localparam int NO = stage_count(NUM_INPUTS, s);
        localparam int OW = stage_width(INPUT_WIDTH, s);

        logic [NO*OW-1:0] sums;

        accumulating_adder_tree_stage #(
            .NUM_IN     (NI),
            .IN_WIDTH   (IW),
            .REGISTERED (stage_registered(s, S, REG_EVERY))
        ) u_stage (
            .clk       (clk),
            .arst_n    (arst_n_in),
            .en        (en),
            .operands  (tree_data[s][NI*IW-1:0]),
            .op_valid  (tree_valid[s]),
            .op_last   (tree_last[s]),
            .sums      (sums),
            .sum_valid (tree_valid[s+1]),
            .sum_last  (tree_last[s+1])
        );

        assign tree_data[s+1] = FLAT_W'(sums);
    end

    logic unused_tree;
    assign unused_tree = ^tree_data;

    // ---- accumulator stage boundary ----
    logic signed [TREE_W-1:0]    beat_p;
    logic signed [OUT_WIDTH-1:0] beat_ext;
    logic signed [OUT_WIDTH-1:0] acc;
    logic signed [OUT_WIDTH-1:0] sum_c;
    logic [BEATS_W-1:0]          cnt;
    logic [BEATS_W-1:0]          cnt_c;
    logic                        ovf;
    logic                        ovf_c;
    logic                        first;

    assign beat_p = tree_data[S][TREE_W-1:0];

    // Next sum / count / overflow for the beat leaving the tree.
    always_comb begin
        beat_ext = OUT_WIDTH'(beat_p);
        sum_c    = beat_ext;
        cnt_c    = BEATS_W'(1);
        ovf_c    = 1'b0;
        if (!first) begin
            sum_c = acc + beat_ext;
            cnt_c = sat_inc(cnt);
            ovf_c = ovf || (cnt == BEATS_W'(MAX_BEATS));
        end
    end

    // Accumulate non-final beats; publish the packet result on the last beat.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            acc          <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            first        <= 1'b1;
            out          <= '0;
            out_beats    <= '0;
            out_overflow <= 1'b0;
            out_valid    <= 1'b0;
        end else if (en) begin
            out_valid <= tree_valid[S] && tree_last[S];
            if (tree_valid[S]) begin
                if (tree_last[S]) begin
                    out          <= sum_c;
                    out_beats    <= cnt_c;
                    out_overflow <= ovf_c;
                    first        <= 1'b1;
                end else begin
                    acc   <= sum_c;
                    cnt   <= cnt_c;
                    ovf   <= ovf_c;
                    first <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/accumulating_adder_tree.md
# accumulating_adder_tree

Parametrised, pipelined signed adder tree that reduces `NUM_INPUTS` lanes per beat and accumulates consecutive beats into one sum. A packet is a run of beats closed by `in_last`. Pipeline depth is configurable through register insertion, and a single valid/ready stall freezes the whole datapath. It sits between the MAC/product array and the output/requantisation stage of the convolution datapath, and replaces the single-shot tree where one kernel window's products span more than one beat.

## Interface
- `NUM_INPUTS`, 36, lanes per beat; must be ≥ 2.
- `INPUT_WIDTH`, 32, signed lane width.
- `REG_EVERY`, 1, pipeline register after every `REG_EVERY` tree stages; the final stage is always registered.
- `MAX_BEATS`, 16, beats per packet guaranteed free of overflow; must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `arst_n_in` in 1: reset, asynchronous and active-low.
- `in` in `NUM_INPUTS` × `INPUT_WIDTH`: signed lane vector.
- `in_valid` in 1: beat present.
- `in_last` in 1: beat closes the packet.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `out` out `OUT_WIDTH` = `INPUT_WIDTH` + clog2(`NUM_INPUTS`) + clog2(`MAX_BEATS`): signed packet sum.
- `out_beats` out clog2(`MAX_BEATS`+1): beats in the packet, saturating at `MAX_BEATS`.
- `out_overflow` out 1: packet exceeded `MAX_BEATS` beats.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts the result.

## Operation
- Tree structure:
  - `S` = clog2(`NUM_INPUTS`) stages.
  - Stage s outputs ceil(`NUM_INPUTS`/2^(s+1)) words of width `INPUT_WIDTH`+s+1.
  - Pairs are added with sign extension. An odd orphan is sign-extended by one bit and passed through.
- Stage s is registered when (s+1) mod `REG_EVERY` = 0 or s = `S`−1. There are `P` = ceil(`S`/`REG_EVERY`) pipeline registers in total.
- `valid` and `last` travel alongside the data through every registered stage.
- Global enable `en` = !(`out_valid` && !`out_ready`):
  - `in_ready` = `en`.
  - All pipeline, accumulator and output registers update only when `en` = 1.
  - When a stage is not valid, its data registers may hold stale values, but its `valid` bit is 0.
- Accumulator (`OUT_WIDTH` bits, plus `first` flag, plus beat counter) acts on each valid tree-output beat:
  - Sum: `first` → sum = beat (sign-extended); otherwise sum = `acc` + beat. The addition wraps modulo 2^`OUT_WIDTH`.
  - Beat counter: count = `first` ? 1 : count+1, saturating at `MAX_BEATS`. If a beat arrives while count is already `MAX_BEATS`, the sticky overflow flag is set; `first` clears it.
  - Not `last`: `acc` ← sum, count updated, `first` ← 0.
  - `last`: `out` ← sum, `out_beats` ← count, `out_overflow` ← flag, `out_valid` ← 1, `first` ← 1.
- `out_valid` clears on `out_ready` when no new result lands in the same cycle.
- Simultaneous `out_ready` and a landing result: `out` is replaced and `out_valid` stays 1, so results are back-to-back with no bubble.
- A single-beat packet (`in_valid` && `in_last`) is legal.
- Beats with `in_valid` = 0 are bubbles. They do not affect `acc` or `first`.
- Reset (any time, including mid-packet) has immediate asynchronous effect:
  - Clears all valid bits, `acc`, and the counter; sets `first` = 1.
  - All outputs go to 0. `in_ready` follows `en` = 1.
  - Partial packets are discarded.

## Timing
- Latency from accepting the `last` beat to `out_valid`: `P`+1 cycles when not stalled. Each stalled cycle adds one.
- Throughput: one beat per cycle while `out_ready` = 1 or `out_valid` = 0.
- `in_ready` depends combinationally on `out_ready`. This is the only input-to-output combinational path.
- Critical path: `REG_EVERY` adder levels. The accumulator adder is a separate registered level.

## Structure
- `accumulating_adder_tree_pkg` holds these functions, used for port widths and generate bounds:
  - `tree_stages(n)`
  - `stage_count(n, s)` (words at stage s)
  - `stage_width(w, s)`
  - `num_pipe_regs(n, r)`
- Sub-module `accumulating_adder_tree_stage` is one reduction level. Parameters: `NUM_IN`, `IN_WIDTH`, `REGISTERED`. It carries `valid`/`last` and takes `en`. The top instantiates it `S` times in a generate loop using per-stage packed arrays, not hierarchical references into generate blocks.
- The accumulator/output logic lives in the top module.

## Test plan
1. Config `NUM_INPUTS`=4, `INPUT_WIDTH`=8, `REG_EVERY`=1, `MAX_BEATS`=4. Drive one beat of all lanes = 127 with `last` → `out` = 508, `out_beats` = 1, `out_valid` exactly 3 cycles after acceptance.
2. Sign and orphan handling:
   - Same config, all lanes = −128, `last` → `out` = −512.
   - `NUM_INPUTS`=5, lanes {1, 2, 3, 4, −5} → `out` = 5.
3. Three beats of all lanes = 1, `last` on beat 3, then an immediate next packet of one beat of lanes = 2 → `out` = 12 with `out_beats` = 3, then `out` = 8 with `out_beats` = 1, on consecutive cycles, with no lost beat.
4. Back-pressure:
   - Stream 8 single-beat packets (lane values k) with `out_ready` = 0 from cycle 5 to cycle 10 → `in_ready` = 0 for exactly those cycles.
   - All 8 results are 4k, in order; none duplicated or dropped.
5. Overflow: `MAX_BEATS`=2, 3 beats of lanes = 1 → `out` = 12, `out_beats` = 2, `out_overflow` = 1. The next 1-beat packet gives `out_overflow` = 0.
6. Reset mid-packet: assert `arst_n_in` = 0 after beat 2 of 3, then release and send a 1-beat packet of lanes = 3 → `out` = 12, `out_beats` = 1. All outputs read 0 during reset.
